// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Signal bundle between the core's fetch and data ports, the
//               mem_arbiter, and the shared single-port memory.
//               slave  : arbiter view (core requests in, memory handshake out)
//               master : environment view (core ports and memory model)
// Ports       : fetch  - i_req, i_addr, i_gnt, i_rvalid, i_rdata
//               data   - d_req, d_we, d_addr, d_wdata, d_wstrb,
//                        d_gnt, d_rvalid, d_rdata
//               memory - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
//                        mem_ready, mem_rvalid, mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 10
);
    // Instruction-fetch port (read only)
    logic                 i_req;
    logic [ADDR-1:0]      i_addr;
    logic                 i_gnt;
    logic                 i_rvalid;
    logic [WIDTH-1:0]     i_rdata;

    // Data load/store port
    logic                 d_req;
    logic                 d_we;
    logic [ADDR-1:0]      d_addr;
    logic [WIDTH-1:0]     d_wdata;
    logic [WIDTH/8-1:0]   d_wstrb;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [WIDTH-1:0]     d_rdata;

    // Shared memory port
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR-1:0]      mem_addr;
    logic [WIDTH-1:0]     mem_wdata;
    logic [WIDTH/8-1:0]   mem_wstrb;
    logic                 mem_ready;
    logic                 mem_rvalid;
    logic [WIDTH-1:0]     mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between the instruction-fetch
//               port and the data load/store port. Arbitration is per
//               transaction: data has priority, but after STARVE_LIMIT
//               consecutive data grants with fetch waiting, fetch wins.
//               At most one read is outstanding at the memory; stores
//               complete at grant so they stream at one per cycle.
// Ports       : clk     - clock, rising-edge
//               reset_n - asynchronous active-low reset; all outputs 0
//               bus     - mem_arbiter_if.slave (fetch, data, memory signals)
// Parameters  : WIDTH        - data width (multiple of 8)
//               ADDR         - byte address width
//               STARVE_LIMIT - data grants tolerated while fetch waits (>=1)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDR         = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    mem_arbiter_if.slave    bus
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_starve_cnt;
    logic [WIDTH-1:0]     r_i_rdata;
    logic [WIDTH-1:0]     r_d_rdata;

    logic                 w_idle;
    logic                 w_sel_i;
    logic                 w_sel_d;
    logic                 w_i_gnt;
    logic                 w_d_gnt;
    logic                 w_i_ret;
    logic                 w_d_ret;

    logic                 w_mem_req;
    logic                 w_mem_we;
    logic [ADDR-1:0]      w_mem_addr;
    logic [WIDTH-1:0]     w_mem_wdata;
    logic [WIDTH/8-1:0]   w_mem_wstrb;
    logic [WIDTH-1:0]     w_i_rdata;
    logic [WIDTH-1:0]     w_d_rdata;

    // ------------------------------------------------------------------------
    // Selection: only in IDLE. Data wins a tie unless fetch has already
    // watched STARVE_LIMIT data grants go by.
    // ------------------------------------------------------------------------
    assign w_idle  = (r_state == ST_IDLE);
    assign w_sel_i = w_idle & bus.i_req & (~bus.d_req | (r_starve_cnt == c_LIMIT));
    assign w_sel_d = w_idle & bus.d_req & ~w_sel_i;

    assign w_i_gnt = w_sel_i & bus.mem_ready;
    assign w_d_gnt = w_sel_d & bus.mem_ready;

    // Read returns are only honoured in the matching wait state; a stray
    // mem_rvalid in IDLE (e.g. after an aborted read) falls through here.
    assign w_i_ret = (r_state == ST_WAIT_I) & bus.mem_rvalid;
    assign w_d_ret = (r_state == ST_WAIT_D) & bus.mem_rvalid;

    // ------------------------------------------------------------------------
    // Memory-side mux. Everything is forced to zero while reset is asserted
    // because the IDLE selection would otherwise pass requests straight out.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_wstrb = '0;
        if (reset_n) begin
            if (w_sel_i) begin
                w_mem_req  = 1'b1;
                w_mem_addr = bus.i_addr;
            end else if (w_sel_d) begin
                w_mem_req   = 1'b1;
                w_mem_we    = bus.d_we;
                w_mem_addr  = bus.d_addr;
                w_mem_wdata = bus.d_wdata;
                // Loads present all-zero byte enables to the memory.
                w_mem_wstrb = bus.d_we ? bus.d_wstrb : '0;
            end
        end
    end

    // Read data is forwarded in the return cycle and held afterwards.
    always_comb begin
        w_i_rdata = '0;
        w_d_rdata = '0;
        if (reset_n) begin
            w_i_rdata = w_i_ret ? bus.mem_rdata : r_i_rdata;
            w_d_rdata = w_d_ret ? bus.mem_rdata : r_d_rdata;
        end
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_wstrb = w_mem_wstrb;

    assign bus.i_gnt     = reset_n & w_i_gnt;
    assign bus.d_gnt     = reset_n & w_d_gnt;
    assign bus.i_rvalid  = reset_n & w_i_ret;
    assign bus.d_rvalid  = reset_n & w_d_ret;
    assign bus.i_rdata   = w_i_rdata;
    assign bus.d_rdata   = w_d_rdata;

    // ------------------------------------------------------------------------
    // Transaction state, starvation counter and read-data holding registers.
    // Reset abandons any pending read; the requester has to ask again.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_i_gnt) begin
                        r_state <= ST_WAIT_I;
                    end else if (w_d_gnt && !bus.d_we) begin
                        r_state <= ST_WAIT_D;
                    end
                    // A granted store finishes here; IDLE stays so the next
                    // store can be granted on the following cycle.
                end
                ST_WAIT_I: begin
                    if (bus.mem_rvalid) begin
                        r_i_rdata <= bus.mem_rdata;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_WAIT_D: begin
                    if (bus.mem_rvalid) begin
                        r_d_rdata <= bus.mem_rdata;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Counts data grants fetch has had to watch; saturates so that
            // the fetch-wins condition is stable until fetch is granted.
            if (!bus.i_req || w_i_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_d_gnt && (r_starve_cnt != c_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed-stimulus bench for mem_arbiter with a transaction-
//               level reference model checked every cycle, plus literal
//               expectations for reset, single fetch, store stream,
//               starvation, backpressure and stray-rvalid/abort cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int W     = 32;
    localparam int A     = 10;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic           i_req = 1'b0;
    logic [A-1:0]   i_addr = '0;
    logic           d_req = 1'b0;
    logic           d_we = 1'b0;
    logic [A-1:0]   d_addr = '0;
    logic [W-1:0]   d_wdata = '0;
    logic [W/8-1:0] d_wstrb = '0;
    logic           mem_ready = 1'b0;
    logic           mem_rvalid = 1'b0;
    logic [W-1:0]   mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter_if #(.WIDTH(W), .ADDR(A)) bus ();

    assign bus.i_req      = i_req;
    assign bus.i_addr     = i_addr;
    assign bus.d_req      = d_req;
    assign bus.d_we       = d_we;
    assign bus.d_addr     = d_addr;
    assign bus.d_wdata    = d_wdata;
    assign bus.d_wstrb    = d_wstrb;
    assign bus.mem_ready  = mem_ready;
    assign bus.mem_rvalid = mem_rvalid;
    assign bus.mem_rdata  = mem_rdata;

    mem_arbiter #(.WIDTH(W), .ADDR(A), .STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Reference model: tracks which port (if any) owns the one outstanding
    // read, how many data grants fetch has watched, and the last data each
    // port received.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic           i_gnt;
        logic           i_rvalid;
        logic [W-1:0]   i_rdata;
        logic           d_gnt;
        logic           d_rvalid;
        logic [W-1:0]   d_rdata;
        logic           mem_req;
        logic           mem_we;
        logic [A-1:0]   mem_addr;
        logic [W-1:0]   mem_wdata;
        logic [W/8-1:0] mem_wstrb;
    } out_t;

    string        m_owner = "none";   // "none", "fetch" or "data"
    int           m_waited = 0;       // data grants seen while fetch waits
    logic [W-1:0] m_last_i = '0;
    logic [W-1:0] m_last_d = '0;

    function automatic out_t model_out();
        out_t o;
        bit   fetch_turn;
        o = '0;
        if (!reset_n) return o;
        o.i_rdata = m_last_i;
        o.d_rdata = m_last_d;
        if (m_owner != "none") begin
            if (mem_rvalid && m_owner == "fetch") begin
                o.i_rvalid = 1'b1;
                o.i_rdata  = mem_rdata;
            end
            if (mem_rvalid && m_owner == "data") begin
                o.d_rvalid = 1'b1;
                o.d_rdata  = mem_rdata;
            end
            return o;
        end
        fetch_turn = i_req && (!d_req || m_waited >= LIMIT);
        if (fetch_turn) begin
            o.mem_req  = 1'b1;
            o.mem_addr = i_addr;
            o.i_gnt    = mem_ready;
        end else if (d_req) begin
            o.mem_req   = 1'b1;
            o.mem_we    = d_we;
            o.mem_addr  = d_addr;
            o.mem_wdata = d_wdata;
            o.mem_wstrb = d_we ? d_wstrb : '0;
            o.d_gnt     = mem_ready;
        end
        return o;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        out_t o;
        if (!reset_n) begin
            m_owner  = "none";
            m_waited = 0;
            m_last_i = '0;
            m_last_d = '0;
        end else begin
            o = model_out();
            if (o.i_rvalid) begin
                m_last_i = mem_rdata;
                m_owner  = "none";
            end else if (o.d_rvalid) begin
                m_last_d = mem_rdata;
                m_owner  = "none";
            end else if (o.i_gnt) begin
                m_owner = "fetch";
            end else if (o.d_gnt && !d_we) begin
                m_owner = "data";
            end
            if (!i_req || o.i_gnt)  m_waited = 0;
            else if (o.d_gnt)       m_waited = (m_waited < LIMIT) ? m_waited + 1 : LIMIT;
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        out_t e;
        e = model_out();
        chk("m_i_gnt",     bus.i_gnt,     e.i_gnt);
        chk("m_i_rvalid",  bus.i_rvalid,  e.i_rvalid);
        chk("m_i_rdata",   bus.i_rdata,   e.i_rdata);
        chk("m_d_gnt",     bus.d_gnt,     e.d_gnt);
        chk("m_d_rvalid",  bus.d_rvalid,  e.d_rvalid);
        chk("m_d_rdata",   bus.d_rdata,   e.d_rdata);
        chk("m_mem_req",   bus.mem_req,   e.mem_req);
        chk("m_mem_we",    bus.mem_we,    e.mem_we);
        chk("m_mem_addr",  bus.mem_addr,  e.mem_addr);
        chk("m_mem_wdata", bus.mem_wdata, e.mem_wdata);
        chk("m_mem_wstrb", bus.mem_wstrb, e.mem_wstrb);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed scenarios with literal expectations.
    // ------------------------------------------------------------------------
    initial begin
        // Reset with both ports requesting.
        i_req = 1'b1; i_addr = 10'h040;
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h0F0; d_wdata = 32'h11223344; d_wstrb = 4'hF;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_i_gnt",   bus.i_gnt,   0);
        chk("rst_d_gnt",   bus.d_gnt,   0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        step(); reset_n = 1'b1;
        @(negedge clk);
        chk("rel_d_gnt",    bus.d_gnt,    1);
        chk("rel_i_gnt",    bus.i_gnt,    0);
        chk("rel_mem_addr", bus.mem_addr, 10'h0F0);
        step(); i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("idle_mem_req", bus.mem_req, 0);

        // Single fetch with two-cycle memory latency.
        step(); i_req = 1'b1; i_addr = 10'h010; d_we = 1'b0;
        @(negedge clk);
        chk("f_i_gnt",     bus.i_gnt,     1);
        chk("f_mem_addr",  bus.mem_addr,  10'h010);
        chk("f_mem_wstrb", bus.mem_wstrb, 0);
        step(); i_req = 1'b0;
        @(negedge clk);
        chk("f_wait_req", bus.mem_req, 0);
        chk("f_wait_gnt", bus.i_gnt,   0);
        step(); mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        @(negedge clk);
        chk("f_i_rvalid", bus.i_rvalid, 1);
        chk("f_i_rdata",  bus.i_rdata,  32'h00500093);
        chk("f_ret_req",  bus.mem_req,  0);
        step(); mem_rvalid = 1'b0; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("f_rvalid_low", bus.i_rvalid, 0);
        chk("f_rdata_hold", bus.i_rdata,  32'h00500093);

        // Three back-to-back stores.
        for (int k = 0; k < 3; k++) begin
            step(); d_req = 1'b1; d_we = 1'b1; d_addr = 10'(10'h100 + 4 * k);
            d_wdata = 32'hA0000000 + 32'(k); d_wstrb = 4'hF;
            @(negedge clk);
            chk("st_d_gnt",    bus.d_gnt,    1);
            chk("st_mem_addr", bus.mem_addr, 10'h100 + 4 * k);
            chk("st_mem_we",   bus.mem_we,   1);
            chk("st_d_rvalid", bus.d_rvalid, 0);
        end
        step(); d_req = 1'b0;
        @(negedge clk);
        chk("st_end_gnt", bus.d_gnt, 0);

        // Starvation: both held; expect 4 data grants then fetch, twice.
        step(); i_req = 1'b1; i_addr = 10'h020;
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h300; d_wdata = 32'h5A5A5A5A; d_wstrb = 4'h3;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < LIMIT; j++) begin
                @(negedge clk);
                chk("sv_d_gnt", bus.d_gnt, 1);
                chk("sv_i_gnt", bus.i_gnt, 0);
                step(); d_addr = d_addr + 10'd4;
            end
            @(negedge clk);
            chk("sv_fetch_gnt",  bus.i_gnt,    1);
            chk("sv_fetch_dgnt", bus.d_gnt,    0);
            chk("sv_fetch_addr", bus.mem_addr, 10'h020);
            step(); mem_rvalid = 1'b1; mem_rdata = 32'hC0DE0000 + 32'(r);
            if (r == 1) begin i_req = 1'b0; d_req = 1'b0; end
            @(negedge clk);
            chk("sv_i_rvalid", bus.i_rvalid, 1);
            chk("sv_i_rdata",  bus.i_rdata,  32'hC0DE0000 + r);
            step(); mem_rvalid = 1'b0;
        end

        // Backpressure on a load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h200; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_d_gnt",    bus.d_gnt,    0);
            chk("bp_mem_req",  bus.mem_req,  1);
            chk("bp_mem_addr", bus.mem_addr, 10'h200);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("bp_grant", bus.d_gnt, 1);
        step(); d_req = 1'b0;
        @(negedge clk);
        chk("bp_wait_req", bus.mem_req, 0);
        step(); mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("bp_d_rvalid", bus.d_rvalid, 1);
        chk("bp_d_rdata",  bus.d_rdata,  32'h12345678);
        chk("bp_i_rvalid", bus.i_rvalid, 0);
        step(); mem_rvalid = 1'b0;

        // Abort a load with reset, then a stray mem_rvalid in IDLE.
        d_req = 1'b1; d_addr = 10'h204;
        @(negedge clk);
        chk("ab_d_gnt", bus.d_gnt, 1);
        step(); d_req = 1'b0;
        @(negedge clk);
        chk("ab_wait_req", bus.mem_req, 0);
        step(); reset_n = 1'b0;
        @(negedge clk);
        chk("ab_rst_d_rdata", bus.d_rdata, 0);
        chk("ab_rst_i_rdata", bus.i_rdata, 0);
        step(); reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ab_stray_rvalid", bus.d_rvalid, 0);
        chk("ab_stray_rdata",  bus.d_rdata,  0);
        step(); mem_rvalid = 1'b0; d_req = 1'b1; d_addr = 10'h208;
        @(negedge clk);
        chk("ab_idle_gnt",  bus.d_gnt,    1);
        chk("ab_idle_addr", bus.mem_addr, 10'h208);
        step(); d_req = 1'b0;
        step(); mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("ab_d_rvalid", bus.d_rvalid, 1);
        chk("ab_d_rdata",  bus.d_rdata,  32'h0BADF00D);
        step(); mem_rvalid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
